// File: rtl/simplez_pkg.sv
// Shared widths, sizes and loader state encoding for the simplez program memory path.
package simplez_pkg;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 12;
  localparam int MEM_DEPTH = 512;
  localparam int LEN_W     = 10;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    LS_IDLE     = 3'd0,
    LS_LEN_HI   = 3'd1,
    LS_LEN_LO   = 3'd2,
    LS_DATA_HI  = 3'd3,
    LS_DATA_LO  = 3'd4,
    LS_DONE     = 3'd5,
    LS_CHECKSUM = 3'd6
  } loader_state_e;

  // A load must carry at least one word and no more than fits in memory.
  function automatic logic len_ok(input len_t len);
    return (len != '0) && (len <= len_t'(MEM_DEPTH));
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: length then 12-bit words; mem_we one cycle after each DATA_LO byte.
// No backpressure, every rx_valid is consumed; optional trailing checksum via PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import simplez_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 9'h000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE     = LS_IDLE;
  localparam logic [2:0] LEN_HI   = LS_LEN_HI;
  localparam logic [2:0] LEN_LO   = LS_LEN_LO;
  localparam logic [2:0] DATA_HI  = LS_DATA_HI;
  localparam logic [2:0] DATA_LO  = LS_DATA_LO;
  localparam logic [2:0] DONE     = LS_DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECKSUM = LS_CHECKSUM;
`endif

  logic [2:0]        state_q;
  len_t              len_q;
  len_t              cnt_q;
  len_t              cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        word_hi_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign cnt_nxt = cnt_q + len_t'(1);
  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign done    = (state_q == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      word_hi_q <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= LEN_HI;
            err     <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (rx_valid) begin
            len_q[9:8] <= rx_data[1:0];
            state_q    <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (rx_valid) begin
            len_q[7:0] <= rx_data;
            if (len_ok({len_q[9:8], rx_data})) begin
              state_q <= DATA_HI;
            end else begin
              state_q <= DONE;
              err     <= 1'b1;
            end
          end
        end
        DATA_HI: begin
          if (rx_valid) begin
            word_hi_q <= rx_data[3:0];
            state_q   <= DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + rx_data;
`endif
          end
        end
        DATA_LO: begin
          if (rx_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= {word_hi_q, rx_data};
            addr_q    <= addr_q + ADDR_W'(1);
            cnt_q     <= cnt_nxt;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + rx_data;
            state_q   <= (cnt_nxt == len_q) ? CHECKSUM : DATA_HI;
`else
            state_q   <= (cnt_nxt == len_q) ? DONE : DATA_HI;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECKSUM: begin
          if (rx_valid) begin
            if (rx_data != sum_q) err <= 1'b1;
            state_q <= DONE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench: two loaders (base 0 and base 1FF) share stimulus; a queue-based model predicts writes and err.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [8:0]  a_addr, b_addr;
  logic [11:0] a_wdata, b_wdata;
  logic        a_we, b_we, a_busy, b_busy, a_done, b_done, a_err, b_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim[$];
  logic [20:0] exp_a[$], exp_b[$];
  logic [20:0] wq_a[$], wq_b[$];
  logic        exp_err;
  logic        a_we_d = 1'b0;
  int          we_run = 0;

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(9'h000)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  prog_loader #(.BASE_ADDR(9'h1FF)) u_wrap (
    .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  always @(negedge clk) begin
    if (a_we) wq_a.push_back({a_addr, a_wdata});
    if (b_we) wq_b.push_back({b_addr, b_wdata});
    if (a_we && a_we_d) we_run++;
    a_we_d = a_we;
  end

  // Reference: length field, then word pairs, then (optionally) a checksum byte.
  task automatic model_load();
    int len;
    logic [7:0]  sum;
    logic [11:0] w;
    exp_a.delete();
    exp_b.delete();
    exp_err = 1'b0;
    len = {stim[0][1:0], stim[1]};
    if (len == 0 || len > 512) begin
      exp_err = 1'b1;
      return;
    end
    sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      w = {stim[2+2*i][3:0], stim[3+2*i]};
      exp_a.push_back({9'(i % 512), w});
      exp_b.push_back({9'((511 + i) % 512), w});
      sum = sum + stim[2+2*i] + stim[3+2*i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (stim[2+2*len] != sum) exp_err = 1'b1;
`endif
  endtask

  task automatic make_stim(input int len_field, input int nwords, input bit corrupt);
    logic [7:0] b, sum;
    logic [9:0] lf;
    stim.delete();
    lf = len_field[9:0];
    b = 8'($urandom);
    b[1:0] = lf[9:8];
    stim.push_back(b);
    stim.push_back(lf[7:0]);
    sum = 8'h00;
    for (int i = 0; i < 2*nwords; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      sum = sum + b;
    end
    stim.push_back(corrupt ? 8'(sum + 8'h01) : sum);
  endtask

  task automatic run_load(input string name, input int max_gap, input int start_at);
    int t;
    wq_a.delete();
    wq_b.delete();
    model_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_done !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL %s start_ack: busy/done/err %b%b%b expected 100", name, a_busy, a_done, a_err);
    end
    for (int i = 0; i < stim.size(); i++) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      rx_data  = stim[i];
      rx_valid = 1'b1;
      start    = (i == start_at);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    t = 0;
    while (!(a_done && b_done) && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || b_done !== 1'b1 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: done %b/%b busy %b/%b expected done 1 busy 0", name, a_done, b_done, a_busy, b_busy);
    end
    checks++;
    if (a_err !== exp_err || b_err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b/%b expected %b", name, a_err, b_err, exp_err);
    end
    checks++;
    if (wq_a.size() != exp_a.size() || wq_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d/%0d expected %0d", name, wq_a.size(), wq_b.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        checks++;
        if (wq_a[i] !== exp_a[i] || wq_b[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL %s write[%0d]: got %h/%h expected %h/%h", name, i, wq_a[i], wq_b[i], exp_a[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_we, a_busy, a_done, a_err, a_addr, a_wdata} !== 25'd0 ||
        {b_we, b_busy, b_done, b_err, b_addr, b_wdata} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: a=%h b=%h expected all zero",
               {a_we, a_busy, a_done, a_err, a_addr, a_wdata}, {b_we, b_busy, b_done, b_err, b_addr, b_wdata});
    end
    rstn = 1'b1;
    wq_a.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'($urandom);
    end
    @(negedge clk); rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wq_a.size() != 0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_rx: writes %0d busy %b done %b expected 0 0 0", wq_a.size(), a_busy, a_done);
    end
  endtask

  task automatic test_basic();
    stim = '{8'h00, 8'h02, 8'h00, 8'hAB, 8'h0F, 8'hFF, 8'hB9};
    run_load("basic", 0, -1);
    checks++;
    if (wq_a.size() != 2 || wq_b.size() != 2) begin
      errors++;
      $display("FAIL basic_fixed_count: got %0d/%0d expected 2", wq_a.size(), wq_b.size());
    end else begin
      checks++;
      if (wq_a[0] !== {9'h000, 12'h0AB} || wq_a[1] !== {9'h001, 12'hFFF}) begin
        errors++;
        $display("FAIL basic_fixed_writes: got %h %h expected 000_0ab 001_fff", wq_a[0], wq_a[1]);
      end
      checks++;
      if (wq_b[0] !== {9'h1FF, 12'h0AB} || wq_b[1] !== {9'h000, 12'hFFF}) begin
        errors++;
        $display("FAIL wrap_fixed_writes: got %h %h expected 1ff_0ab 000_fff", wq_b[0], wq_b[1]);
      end
    end
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %b expected 0", a_err);
    end
  endtask

  task automatic test_bad_len();
    stim = '{8'h00, 8'h00};
    run_load("len_zero", 1, -1);
    checks++;
    if (a_err !== 1'b1 || wq_a.size() != 0) begin
      errors++;
      $display("FAIL len_zero_fixed: err %b writes %0d expected 1 0", a_err, wq_a.size());
    end
    stim = '{8'h02, 8'h01, 8'h12, 8'h34};
    run_load("len_513", 1, -1);
    checks++;
    if (a_err !== 1'b1 || wq_a.size() != 0) begin
      errors++;
      $display("FAIL len_513_fixed: err %b writes %0d expected 1 0", a_err, wq_a.size());
    end
  endtask

  task automatic test_mid_reset();
    wq_a.delete();
    wq_b.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h00; @(negedge clk);
    rx_data = 8'h03; @(negedge clk);
    rx_data = 8'h05; @(negedge clk);
    rx_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({a_we, a_busy, a_done, a_err, a_addr, a_wdata} !== 25'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0", {a_we, a_busy, a_done, a_err, a_addr, a_wdata});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (wq_a.size() != 0 || wq_b.size() != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_write: writes %0d/%0d busy %b expected 0", wq_a.size(), wq_b.size(), a_busy);
    end
    make_stim(3, 3, 1'b0);
    run_load("after_reset", 1, -1);
  endtask

  task automatic test_back_to_back();
    we_run = 0;
    make_stim(4, 4, 1'b0);
    run_load("back_to_back", 0, 5);
    checks++;
    if (we_run != 0) begin
      errors++;
      $display("FAIL we_pulse_width: multi-cycle mem_we seen %0d times expected 0", we_run);
    end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(16, 1);
      if (k % 5 == 4) make_stim(($urandom_range(1, 0) == 0) ? 0 : $urandom_range(1023, 513), 0, 1'b0);
      else            make_stim(n, n, ($urandom_range(3, 0) == 0));
      run_load("random", 2, -1);
    end
    make_stim(512, 512, 1'b0);
    run_load("full_512", 0, 300);
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim = '{8'h00, 8'h02, 8'h00, 8'hAB, 8'h0F, 8'hFF, 8'hB8};
    run_load("checksum_bad", 0, -1);
    checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("FAIL checksum_bad_fixed: err %b expected 1", a_err);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 9'h000, first memory address written by a load.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low; one clock, no other clock domains.
REQ-004 start  input  1  single-cycle request to begin a load.
REQ-005 rx_data  input  8  received byte from serial receiver.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_data valid; may occur on consecutive cycles.
REQ-007 mem_addr  output  9  write address to program memory.
REQ-008 mem_wdata  output  12  write data to program memory.
REQ-009 mem_we  output  1  write strobe, exactly one clk cycle per word.
REQ-010 busy  output  1  high while a load is in progress (CPU held off).
REQ-011 done  output  1  high after load end until next accepted start.
REQ-012 err  output  1  high when the load ended abnormally; valid while done is high.

Function
REQ-013 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE.
REQ-014 IDLE/DONE: start=1 -> LEN_HI, busy=1, done=0, err=0, word counter=0, address=BASE_ADDR; rx_valid ignored.
REQ-015 start while busy SHALL be ignored.
REQ-016 LEN_HI: on rx_valid, len[9:8]=rx_data[1:0] -> LEN_LO; rx_data[7:2] ignored.
REQ-017 LEN_LO: on rx_valid, len[7:0]=rx_data; len 1..512 -> DATA_HI; len 0 or >512 -> DONE with err=1, no writes.
REQ-018 DATA_HI: on rx_valid, word[11:8]=rx_data[3:0] -> DATA_LO; rx_data[7:4] ignored.
REQ-019 DATA_LO: on rx_valid, mem_wdata={word[11:8],rx_data}, mem_addr=current address, mem_we=1 on next cycle only.
REQ-020 After each write: address+1 mod 512 (wraps 511->0); counter+1; counter==len -> DONE (or CHECKSUM, see REQ-027) else DATA_HI.
REQ-021 Write latency: mem_we asserted in cycle after the DATA_LO rx_valid; byte on that same cycle processed normally (no byte lost).
REQ-022 mem_addr/mem_wdata SHALL hold last written values when mem_we=0.
REQ-023 DONE: busy=0, done=1 held; entering DONE on the same cycle as the final mem_we is permitted.

Reset
REQ-024 rstn=0 at any time, including mid-load: state IDLE, mem_we=0, busy=0, done=0, err=0, mem_addr=0, mem_wdata=0, counters=0; no partial write issued.
REQ-025 First load accepted on first start after rstn deasserts.

Configuration
REQ-026 Macro PROG_LOADER_CHECKSUM_EN selects trailing-checksum support.
REQ-027 Defined: extra state CHECKSUM after last word; next rx_valid byte compared to 8-bit mod-256 sum of all DATA_HI and DATA_LO bytes (full 8 bits as received); mismatch -> err=1; then DONE.
REQ-028 Undefined: no CHECKSUM state, no sum register; err only from REQ-017.

Structure
REQ-029 Shared package simplez_pkg: ADDR_W=9, DATA_W=12, MEM_DEPTH=512, loader state enum.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 start; bytes 00,02,00,AB,0F,FF -> writes (000,0AB),(001,FFF); done=1, err=0, busy=0.
REQ-032 BASE_ADDR=9'h1FF, len=2 -> writes at 1FF then 000 (wrap).
REQ-033 len bytes 00,00 -> no mem_we; done=1, err=1; len 02,01 (513) -> same.
REQ-034 rstn pulse after first DATA_HI of 3-word load -> no mem_we, all outputs zero; fresh load completes.
REQ-035 Back-to-back rx_valid every cycle, len=4 -> 4 writes, consecutive addresses, none lost; start mid-load ignored.
REQ-036 With PROG_LOADER_CHECKSUM_EN: data 00,AB,0F,FF, checksum B9 -> err=0; checksum B8 -> err=1.
